// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle sequencer (master) and the RV32 datapath (slave).
// The master drives the strobes and selects; the slave returns the IR contents and status.
interface multicycle_control_if;
  logic [31:0] Instr;
  logic        Zero;
  logic        MemReady;
  logic        PCWrite;
  logic        AdrSrc;
  logic        MemWrite;
  logic        IRWrite;
  logic        RegWrite;
  logic [1:0]  ResultSrc;
  logic [1:0]  ALUSrcA;
  logic [1:0]  ALUSrcB;
  logic [2:0]  ALUControl;
  logic [1:0]  ImmControl;
  logic        Illegal;

  modport master (
    input  Instr, Zero, MemReady,
    output PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmControl, Illegal
  );

  modport slave (
    output Instr, Zero, MemReady,
    input  PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
           ResultSrc, ALUSrcA, ALUSrcB, ALUControl, ImmControl, Illegal
  );
endinterface

// File: rtl/multicycle_control.sv
// Moore sequencer for the RV32 multicycle datapath (lw, sw, R/I ALU ops, beq, optional jal).
// Define RV_JAL_EN to build the JAL state; otherwise opcode 1101111 is reported as illegal.
module multicycle_control (
  input logic                  clk,
  input logic                  reset,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ
`ifdef RV_JAL_EN
    , JAL
`endif
  } state_t;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  state_t      state, next;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct3_ok;
  logic        unused_instr;

  assign opcode    = bus.Instr[6:0];
  assign funct3    = bus.Instr[14:12];
  assign funct3_ok = (funct3 == 3'b000) || (funct3 == 3'b010) ||
                     (funct3 == 3'b110) || (funct3 == 3'b111);
  assign unused_instr = ^{bus.Instr[31], bus.Instr[29:15], bus.Instr[11:7]};

  // Only bit 30 of funct7 matters: it splits add from sub for register-register ops.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic is_r,
                                            input logic b30);
    case (f3)
      3'b000:  alu_decode = (is_r && b30) ? 3'b001 : 3'b000;
      3'b010:  alu_decode = 3'b101;
      3'b110:  alu_decode = 3'b011;
      3'b111:  alu_decode = 3'b010;
      default: alu_decode = 3'b000;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_comb begin
    case (opcode)
      OP_SW:   bus.ImmControl = 2'd1;
      OP_BEQ:  bus.ImmControl = 2'd2;
`ifdef RV_JAL_EN
      OP_JAL:  bus.ImmControl = 2'd3;
`endif
      default: bus.ImmControl = 2'd0;
    endcase
  end

  always_comb begin
    next           = state;
    bus.PCWrite    = 1'b0;
    bus.AdrSrc     = 1'b0;
    bus.MemWrite   = 1'b0;
    bus.IRWrite    = 1'b0;
    bus.RegWrite   = 1'b0;
    bus.ResultSrc  = 2'b00;
    bus.ALUSrcA    = 2'b00;
    bus.ALUSrcB    = 2'b00;
    bus.ALUControl = 3'b000;
    bus.Illegal    = 1'b0;

    case (state)
      FETCH: begin
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        bus.IRWrite   = bus.MemReady;
        bus.PCWrite   = bus.MemReady;
        if (bus.MemReady) next = DECODE;
      end
      DECODE: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b01;
        case (opcode)
          OP_LW, OP_SW: next = MEMADR;
          OP_R:         next = funct3_ok ? EXECR : FETCH;
          OP_I:         next = funct3_ok ? EXECI : FETCH;
          OP_BEQ:       next = BEQ;
`ifdef RV_JAL_EN
          OP_JAL:       next = JAL;
`endif
          default:      next = FETCH;
        endcase
        bus.Illegal = (next == FETCH);
      end
      MEMADR: begin
        bus.ALUSrcA = 2'b10;
        bus.ALUSrcB = 2'b01;
        next = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        if (bus.MemReady) next = MEMWB;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegWrite  = 1'b1;
        next = FETCH;
      end
      MEMWRITE: begin
        bus.AdrSrc   = 1'b1;
        bus.MemWrite = 1'b1;
        if (bus.MemReady) next = FETCH;
      end
      EXECR: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = alu_decode(funct3, 1'b1, bus.Instr[30]);
        next = ALUWB;
      end
      EXECI: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUSrcB    = 2'b01;
        bus.ALUControl = alu_decode(funct3, 1'b0, bus.Instr[30]);
        next = ALUWB;
      end
      ALUWB: begin
        bus.RegWrite = 1'b1;
        next = FETCH;
      end
      BEQ: begin
        bus.ALUSrcA    = 2'b10;
        bus.ALUControl = 3'b001;
        bus.PCWrite    = bus.Zero;
        next = FETCH;
      end
`ifdef RV_JAL_EN
      JAL: begin
        bus.ALUSrcA = 2'b01;
        bus.ALUSrcB = 2'b10;
        bus.PCWrite = 1'b1;
        next = ALUWB;
      end
`endif
      default: next = FETCH;
    endcase

    // Reset suppresses every write immediately and parks the selects at their fetch values.
    if (reset) begin
      bus.PCWrite    = 1'b0;
      bus.AdrSrc     = 1'b0;
      bus.MemWrite   = 1'b0;
      bus.IRWrite    = 1'b0;
      bus.RegWrite   = 1'b0;
      bus.ResultSrc  = 2'b10;
      bus.ALUSrcA    = 2'b00;
      bus.ALUSrcB    = 2'b10;
      bus.ALUControl = 3'b000;
      bus.Illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle output vectors compared against hand-built values.
// Outputs are packed as {PCWrite,AdrSrc,MemWrite,IRWrite,RegWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,ImmControl,Illegal}.
module tb_multicycle_control;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passed = 0;

  multicycle_control_if bus ();
  multicycle_control dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  logic [16:0] obs;
  assign obs = {bus.PCWrite, bus.AdrSrc, bus.MemWrite, bus.IRWrite, bus.RegWrite,
                bus.ResultSrc, bus.ALUSrcA, bus.ALUSrcB, bus.ALUControl,
                bus.ImmControl, bus.Illegal};

  function automatic logic [16:0] mk(input logic pcw, input logic adr, input logic mw,
                                     input logic irw, input logic rw, input logic [1:0] rs,
                                     input logic [1:0] sa, input logic [1:0] sb,
                                     input logic [2:0] alu, input logic [1:0] imm,
                                     input logic ill);
    return {pcw, adr, mw, irw, rw, rs, sa, sb, alu, imm, ill};
  endfunction

  task automatic test_reset;
    reset = 1'b1;
    bus.Instr = 32'h0064A423;
    bus.Zero = 1'b0;
    bus.MemReady = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++;
      if (obs !== mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'd1,0))
        $display("FAIL reset cycle %0d: got %05h want %05h", i, obs,
                 mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'd1,0));
      else passed++;
    end
    reset = 1'b0;
  endtask

  task automatic test_sw;
    logic [16:0] ex [4];
    bus.Instr = 32'h0064A423;
    ex[0] = mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'd1,0);
    ex[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'd1,0);
    ex[2] = mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'd1,0);
    ex[3] = mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'd1,0);
    for (int i = 0; i < 4; i++) begin
      bus.MemReady = 1'b1; #1;
      checks++;
      if (obs !== ex[i]) $display("FAIL sw cycle %0d: got %05h want %05h", i, obs, ex[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq(input logic zero);
    logic [16:0] ex [3];
    bus.Instr = 32'hFE420AE3;
    bus.Zero = zero;
    ex[0] = mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'd2,0);
    ex[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'd2,0);
    ex[2] = mk(zero,0,0,0,0,2'b00,2'b10,2'b00,3'b001,2'd2,0);
    for (int i = 0; i < 3; i++) begin
      bus.MemReady = 1'b1; #1;
      checks++;
      if (obs !== ex[i]) $display("FAIL beq z=%0d cycle %0d: got %05h want %05h", zero, i, obs, ex[i]);
      else passed++;
      @(posedge clk); #1;
    end
    bus.Zero = 1'b0;
  endtask

  task automatic test_lw_stall;
    logic [16:0] ex [7];
    logic [6:0]  mr = 7'b1100111;
    bus.Instr = 32'h00412083;
    ex[0] = mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'd0,0);
    ex[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'd0,0);
    ex[2] = mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'd0,0);
    ex[3] = mk(0,1,0,0,0,2'b00,2'b00,2'b00,3'b000,2'd0,0);
    ex[4] = ex[3];
    ex[5] = ex[3];
    ex[6] = mk(0,0,0,0,1,2'b01,2'b00,2'b00,3'b000,2'd0,0);
    for (int i = 0; i < 7; i++) begin
      bus.MemReady = mr[i]; #1;
      checks++;
      if (obs !== ex[i]) $display("FAIL lw cycle %0d: got %05h want %05h", i, obs, ex[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_alu(input logic [31:0] instr, input logic is_r, input logic [2:0] alu,
                          input logic fetch_stall);
    logic [16:0] ex [5];
    int n;
    bus.Instr = instr;
    n = fetch_stall ? 5 : 4;
    ex[0] = mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'd0,0);
    ex[n-4] = mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'd0,0);
    ex[n-3] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'd0,0);
    ex[n-2] = mk(0,0,0,0,0,2'b00,2'b10,is_r ? 2'b00 : 2'b01,alu,2'd0,0);
    ex[n-1] = mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'd0,0);
    for (int i = 0; i < n; i++) begin
      bus.MemReady = !(fetch_stall && i == 0); #1;
      checks++;
      if (obs !== ex[i]) $display("FAIL alu %08h cycle %0d: got %05h want %05h", instr, i, obs, ex[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal(input logic [31:0] instr);
    logic [16:0] ex [2];
    bus.Instr = instr;
    ex[0] = mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'd0,0);
    ex[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'd0,1);
    for (int i = 0; i < 2; i++) begin
      bus.MemReady = 1'b1; #1;
      checks++;
      if (obs !== ex[i]) $display("FAIL illegal %08h cycle %0d: got %05h want %05h", instr, i, obs, ex[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid;
    logic [16:0] ex [5];
    logic [4:0]  mr = 5'b00111;
    bus.Instr = 32'h0064A423;
    ex[0] = mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'd1,0);
    ex[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'd1,0);
    ex[2] = mk(0,0,0,0,0,2'b00,2'b10,2'b01,3'b000,2'd1,0);
    ex[3] = mk(0,1,1,0,0,2'b00,2'b00,2'b00,3'b000,2'd1,0);
    ex[4] = ex[3];
    for (int i = 0; i < 5; i++) begin
      bus.MemReady = mr[i]; #1;
      checks++;
      if (obs !== ex[i]) $display("FAIL rstmid cycle %0d: got %05h want %05h", i, obs, ex[i]);
      else passed++;
      @(posedge clk); #1;
    end
    reset = 1'b1;
    bus.MemReady = 1'b0; #1;
    checks++;
    if (obs !== mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'd1,0))
      $display("FAIL rstmid during reset: got %05h want %05h", obs,
               mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'd1,0));
    else passed++;
    @(posedge clk); #1;
    reset = 1'b0; #1;
    checks++;
    if (obs !== mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'd1,0))
      $display("FAIL rstmid after reset: got %05h want %05h", obs,
               mk(0,0,0,0,0,2'b10,2'b00,2'b10,3'b000,2'd1,0));
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_jal;
    logic [16:0] ex [4];
    int n;
    bus.Instr = 32'h008000EF;
`ifdef RV_JAL_EN
    n = 4;
    ex[0] = mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'd3,0);
    ex[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'd3,0);
    ex[2] = mk(1,0,0,0,0,2'b00,2'b01,2'b10,3'b000,2'd3,0);
    ex[3] = mk(0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,2'd3,0);
`else
    n = 2;
    ex[0] = mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'd0,0);
    ex[1] = mk(0,0,0,0,0,2'b00,2'b01,2'b01,3'b000,2'd0,1);
    ex[2] = ex[0];
    ex[3] = ex[0];
`endif
    for (int i = 0; i < n; i++) begin
      bus.MemReady = 1'b1; #1;
      checks++;
      if (obs !== ex[i]) $display("FAIL jal cycle %0d: got %05h want %05h", i, obs, ex[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_final_fetch;
    bus.Instr = 32'h00000013;
    bus.MemReady = 1'b1; #1;
    checks++;
    if (obs !== mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'd0,0))
      $display("FAIL final fetch: got %05h want %05h", obs,
               mk(1,0,0,1,0,2'b10,2'b00,2'b10,3'b000,2'd0,0));
    else passed++;
  endtask

  initial begin
    test_reset();
    test_sw();
    test_beq(1'b1);
    test_beq(1'b0);
    test_lw_stall();
    test_alu(32'h40208033, 1'b1, 3'b001, 1'b0);
    test_alu(32'h00208033, 1'b1, 3'b000, 1'b0);
    test_alu(32'h00500093, 1'b0, 3'b000, 1'b1);
    test_alu(32'h0050E093, 1'b0, 3'b011, 1'b0);
    test_alu(32'h00512093, 1'b0, 3'b101, 1'b0);
    test_illegal(32'h0000007F);
    test_illegal(32'h00001013);
    test_reset_mid();
    test_jal();
    test_final_fetch();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Sequencing controller for the RV32 multicycle datapath. It decodes the instruction held in the instruction register and steps a Moore state machine through fetch, decode, execute, memory and writeback. Each cycle it drives the datapath strobes and mux selects, including `ImmControl` for the immediate extender. Memory accesses stall on a ready handshake.

## Interface
- No parameters.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `Instr` in 32: instruction register contents; only `[6:0]`, `[14:12]` and `[30]` are used.
- `Zero` in 1: ALU zero flag.
- `MemReady` in 1: memory completes the current access this cycle.
- `PCWrite` out 1: PC register enable.
- `AdrSrc` out 1: memory address select. 0 selects PC; 1 selects ALUOut.
- `MemWrite` out 1: memory write strobe.
- `IRWrite` out 1: instruction register enable.
- `RegWrite` out 1: register file write enable.
- `ResultSrc` out 2: result mux select. 00 selects ALUOut; 01 selects Data; 10 selects the ALU result.
- `ALUSrcA` out 2: ALU A select. 00 selects PC; 01 selects OldPC; 10 selects rs1.
- `ALUSrcB` out 2: ALU B select. 00 selects rs2; 01 selects ExtendedImm; 10 selects the constant 4.
- `ALUControl` out 3: 000 add, 001 sub, 010 and, 011 or, 101 slt.
- `ImmControl` out 2: 0 = I-type, 1 = S-type, 2 = B-type, 3 = J-type.
- `Illegal` out 1: unsupported-instruction pulse.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
- Any strobe or select not listed for a state is 0.
- FETCH:
  - Drives AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite equal MemReady.
  - Goes to DECODE when MemReady, otherwise holds.
- DECODE:
  - Drives ALUSrcA=01, ALUSrcB=01, add, computing the branch target.
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 → EXECI; 1100011 → BEQ; 1101111 → JAL.
  - Anything else → FETCH with Illegal=1 for this cycle.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add. Goes to MEMREAD for lw, MEMWRITE for sw.
- MEMREAD: AdrSrc=1. Goes to MEMWB when MemReady, otherwise holds.
- MEMWB: ResultSrc=01, RegWrite=1. Goes to FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1, held until MemReady. Goes to FETCH on the MemReady cycle.
- EXECR: ALUSrcA=10, ALUSrcB=00, funct decode. Goes to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, funct decode. Goes to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Goes to FETCH.
- BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero. Goes to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. Goes to ALUWB, which writes PC+4 to rd.
- Funct decode, used by EXECR and EXECI:
  - funct3 000: sub if R-type and Instr[30]=1, else add.
  - funct3 010 → slt; 110 → or; 111 → and.
  - Any other funct3 is illegal. Illegal R/I is detected in DECODE: Illegal=1, then FETCH.
- ImmControl is decoded combinationally from the opcode in every state: lw and ALU-I → 0, sw → 1, beq → 2, jal → 3; all others → 0.

## Timing
- Reset:
  - State returns to FETCH on the next edge.
  - While reset=1, PCWrite, IRWrite, MemWrite, RegWrite and Illegal are forced to 0; selects take their FETCH values.
  - Reset mid-instruction abandons that instruction; no partial writeback occurs after the reset edge.
- Latency with MemReady held at 1:
  - lw 5 cycles.
  - sw, R-type, I-type and jal 4 cycles each.
  - beq 3 cycles.
  - Illegal instruction 2 cycles.
- Each MemReady=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
- MemWrite stays asserted and the address stays stable for the whole wait.
- MemReady is ignored in all other states.

## Configuration
- `RV_JAL_EN` defined: jal is supported as above and ImmControl=3 is reachable.
- `RV_JAL_EN` undefined:
  - The JAL state is not built.
  - Opcode 1101111 is treated as illegal: Illegal pulses in DECODE, then FETCH.
  - ImmControl never takes the value 3.

## Test plan
- **sw:** Instr=0x0064A423, MemReady=1.
  - Sequence FETCH → DECODE → MEMADR → MEMWRITE → FETCH.
  - ImmControl=1 throughout; MemWrite=1 for exactly one cycle with AdrSrc=1.
- **beq:** Instr=0xFE420AE3.
  - With Zero=1: ImmControl=2 and PCWrite=1 in BEQ; 3 cycles total.
  - With Zero=0: PCWrite=0 in BEQ.
- **lw with stall:** lw x1,4(x2) (0x00412083), MemReady=0 for 2 cycles in MEMREAD.
  - MEMREAD lasts 3 cycles and the instruction takes 7 cycles.
  - RegWrite=1 only in MEMWB, with ResultSrc=01.
- **R-type:** sub (0x40208033) gives ALUControl=001 in EXECR; add (0x00208033) gives 000; both 4 cycles.
- **Illegal:** opcode 0x7F, then funct3=001 with opcode 0010011.
  - Each gives Illegal=1 for one cycle in DECODE and then FETCH.
  - RegWrite and MemWrite stay 0.
- **Reset and jal:**
  - Reset asserted during MEMWRITE: MemWrite=0 during reset and state=FETCH after it.
  - jal (0x008000EF): PCWrite=1 in JAL, then RegWrite=1 in ALUWB.
  - With `RV_JAL_EN` undefined, the same jal raises Illegal.
